seq_restoring_divider: RTL

- Iterative restoring divider: the inverse operation of the team's 4x4 array multipliers. It produces an exact quotient and remainder from an 8-bit dividend and a 4-bit divisor.
- Used as the golden reference for recovering operands from products, and for error-distance checks on the approximate multiplier outputs.
- Uses a valid/ready handshake on both sides and resolves one quotient bit per cycle.

---
 rtl/div_pkg.sv | 21 ++
 rtl/div_step.sv | 26 ++
 rtl/seq_restoring_divider.sv | 103 ++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the divider family (restoring, and the planned
// non-restoring / approximate variants).
//   div_state_e : control FSM states
//   DW_DEF/VW_DEF : default dividend/quotient and divisor/remainder widths
//   CW          : step-counter width for the default dividend width
//   QZERO_DIV   : quotient reported for a zero divisor (all ones)
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;
  localparam int CW     = $clog2(DW_DEF);

  localparam logic [DW_DEF-1:0] QZERO_DIV = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step (combinational).
//   i_r   : partial remainder entering the step (always < divisor)
//   i_bit : next dividend bit shifted in
//   i_d   : divisor
//   o_r   : partial remainder leaving the step
//   o_q   : quotient bit produced by the step
module div_step #(
  parameter int VW = 4
) (
  input  logic [VW-1:0] i_r,
  input  logic          i_bit,
  input  logic [VW-1:0] i_d,
  output logic [VW-1:0] o_r,
  output logic          o_q
);

  logic [VW:0] w_t;

  assign w_t = {i_r, i_bit};
  assign o_q = (w_t >= {1'b0, i_d});

  // The result is always < divisor, so the low VW bits of the modular
  // subtraction are exact and the carry bit never needs to be kept.
  assign o_r = w_t[VW-1:0] - (o_q ? i_d : '0);

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative restoring divider, one quotient bit per clock.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid / in_ready   : operand handshake (accepted only in IDLE)
//   dividend, divisor     : unsigned operands (DW / VW bits)
//   out_valid / out_ready : result handshake (result held in DONE)
//   quotient, remainder   : unsigned result (DW / VW bits)
//   div_by_zero           : result came from a zero divisor
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CNTW = (DW > 1) ? $clog2(DW) : 1;

  div_state_e      r_state;
  div_state_e      w_next;
  logic [DW-1:0]   r_q;
  logic [VW-1:0]   r_r;
  logic [VW-1:0]   r_d;
  logic [CNTW-1:0] r_cnt;
  logic            r_dbz;
  logic [VW-1:0]   w_step_r;
  logic            w_step_bit;

  div_step #(.VW(VW)) u_step (
    .i_r   (r_r),
    .i_bit (r_q[DW-1]),
    .i_d   (r_d),
    .o_r   (w_step_r),
    .o_q   (w_step_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (in_valid) w_next = (divisor == '0) ? DONE : RUN;
      RUN:  if (r_cnt == '0) w_next = DONE;
      DONE: if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Q doubles as the dividend shift register and the quotient register:
  // dividend bits leave at the top while quotient bits enter at the bottom.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q   <= '0;
      r_r   <= '0;
      r_d   <= '0;
      r_cnt <= '0;
      r_dbz <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_d <= divisor;
            r_r <= '0;
            if (divisor == '0) begin
              r_q   <= '1;
              r_dbz <= 1'b1;
            end else begin
              r_q   <= dividend;
              r_dbz <= 1'b0;
              r_cnt <= CNTW'(DW - 1);
            end
          end
        end
        RUN: begin
          r_r <= w_step_r;
          r_q <= {r_q[DW-2:0], w_step_bit};
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign quotient    = r_q;
  assign remainder   = r_r;
  assign div_by_zero = r_dbz;

endmodule
